// File: rtl/addsub_seq.sv
// Sequencer for an external 4-bit adder: latches an add/subtract command, drives the
// conditioned operands, waits SETTLE_CYC cycles, captures the result and holds it until consumed.
module addsub_seq #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_mode,
  output logic [3:0] A,
  output logic [3:0] tmp,
  output logic       Cin,
  input  logic [3:0] So,
  input  logic       Cout,
  input  logic       overflow,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_sum,
  output logic       res_cout,
  output logic       res_ovf,
  output logic       ovf_sticky,
  input  logic       ovf_clr,
  output logic [7:0] op_cnt
);

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  state_e     state_q;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] op_a_q, op_b_q;
  logic       op_mode_q;
  logic       cmd_ready_q;
  logic       res_valid_q;
  logic [3:0] res_sum_q;
  logic       res_cout_q;
  logic       res_ovf_q;
  logic       ovf_sticky_q;
  logic [7:0] op_cnt_q, op_cnt_d;

  assign cnt_d    = cnt_q - 4'd1;
  assign op_cnt_d = op_cnt_q + 8'd1;

  // cmd_ready is registered so it stays low during reset and rises on the first edge after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      op_a_q       <= 4'd0;
      op_b_q       <= 4'd0;
      op_mode_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_sum_q    <= 4'd0;
      res_cout_q   <= 1'b0;
      res_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
      op_cnt_q     <= 8'd0;
    end else begin
      if (ovf_clr) begin
        ovf_sticky_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (cmd_ready_q && cmd_valid) begin
            op_a_q      <= cmd_a;
            op_b_q      <= cmd_b ^ {4{cmd_mode}};
            op_mode_q   <= cmd_mode;
            cnt_q       <= CntLoad;
            cmd_ready_q <= 1'b0;
            state_q     <= SETTLE;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_d;
          end else begin
            res_sum_q   <= So;
            res_cout_q  <= Cout;
            res_ovf_q   <= overflow;
            res_valid_q <= 1'b1;
            // A capture with overflow overrides a simultaneous clear.
            if (overflow) begin
              ovf_sticky_q <= 1'b1;
            end
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            op_cnt_q    <= op_cnt_d;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign A          = op_a_q;
  assign tmp        = op_b_q;
  assign Cin        = op_mode_q;
  assign res_valid  = res_valid_q;
  assign res_sum    = res_sum_q;
  assign res_cout   = res_cout_q;
  assign res_ovf    = res_ovf_q;
  assign ovf_sticky = ovf_sticky_q;
  assign op_cnt     = op_cnt_q;

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 Parameter: SETTLE_CYC, default 1, adder settle cycles between operand drive and result capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  operand command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_a  input  4  minuend/augend.
REQ-007 cmd_b  input  4  subtrahend/addend.
REQ-008 cmd_mode  input  1  0 = add, 1 = subtract.
REQ-009 A  output  4  operand A to the 4-bit adder.
REQ-010 tmp  output  4  operand B to the adder, already conditioned for the selected mode.
REQ-011 Cin  output  1  adder carry-in, equal to the latched mode.
REQ-012 So  input  4  adder sum.
REQ-013 Cout  input  1  adder carry-out.
REQ-014 overflow  input  1  adder signed overflow.
REQ-015 res_valid  output  1  result available.
REQ-016 res_ready  input  1  consumer accepts the result.
REQ-017 res_sum  output  4  captured So.
REQ-018 res_cout  output  1  captured Cout.
REQ-019 res_ovf  output  1  captured overflow.
REQ-020 ovf_sticky  output  1  set if any captured result had overflow.
REQ-021 ovf_clr  input  1  synchronous clear of ovf_sticky.
REQ-022 op_cnt  output  8  count of completed result handshakes.

Function
REQ-023 FSM states SHALL be IDLE, SETTLE, HOLD; the reset state SHALL be IDLE.
REQ-024 cmd_ready SHALL be 1 only in IDLE, and cmd_ready is a registered/state decode with no combinational path from cmd_valid.
REQ-025 IDLE with cmd_valid=1 SHALL latch cmd_a, cmd_b, cmd_mode, load the settle counter with SETTLE_CYC-1, and move to SETTLE.
REQ-026 From the latched values, A = op_a, tmp = op_b XOR {4{op_mode}}, Cin = op_mode.
REQ-027 A, tmp and Cin SHALL stay constant through SETTLE and HOLD, and SHALL retain the last values in IDLE.
REQ-028 SETTLE: on each edge with counter != 0, the counter SHALL decrement.
REQ-029 SETTLE: on the edge with counter == 0, the block SHALL capture So, Cout and overflow into res_sum, res_cout and res_ovf, set res_valid, and move to HOLD.
REQ-030 Latency: a command accepted at edge k SHALL have res_valid high after edge k+SETTLE_CYC.
REQ-031 HOLD: res_valid=1, and res_* SHALL stay stable until res_valid && res_ready.
REQ-032 On the handshake edge, the block SHALL clear res_valid, increment op_cnt, and move to IDLE; a new command is accepted no earlier than the next edge.
REQ-033 op_cnt SHALL wrap 255 -> 0 without any flag.
REQ-034 ovf_sticky SHALL be set on a capture edge with overflow=1, and cleared by ovf_clr=1.
REQ-035 If a set and a clear of ovf_sticky occur on the same edge, the set SHALL win.
REQ-036 res_ready outside HOLD SHALL be ignored; cmd_valid outside IDLE SHALL be ignored, so the command is not consumed.
REQ-037 Adder inputs SHALL be sampled only at the capture edge; changes of So, Cout or overflow at other times SHALL have no effect.

Reset
REQ-038 Asserting rst at any time, including mid-SETTLE or mid-HOLD, SHALL force IDLE immediately.
REQ-039 Under reset, A=0, tmp=0, Cin=0, res_sum=0, res_cout=0, res_ovf=0, res_valid=0, ovf_sticky=0, op_cnt=0, and cmd_ready=0 while rst=1.
REQ-040 An in-flight operation SHALL be discarded with no capture and no count.
REQ-041 cmd_ready SHALL become 1 on the first edge after rst deasserts.

Verification
REQ-042 Add, SETTLE_CYC=1, with a behavioural adder model: a=0000, b=0001, mode=0 -> A=0000, tmp=0001, Cin=0; res_sum=0001, cout=0, ovf=0, res_valid one edge after accept.
REQ-043 Subtract: a=1111, b=0001, mode=1 -> tmp=1110, Cin=1; res_sum=1110, cout=1, ovf=0.
REQ-044 Overflow and sticky: 0111+0001 mode 0 -> res_sum=1000, ovf=1, ovf_sticky=1; later ovf_clr alone -> 0; ovf_clr coinciding with an overflow capture -> remains 1.
REQ-045 Backpressure: res_ready=0 for 5 cycles in HOLD -> res_* stable, cmd_ready=0, op_cnt unchanged; res_ready=1 -> op_cnt+1 and IDLE next edge.
REQ-046 SETTLE_CYC=4: res_valid exactly 4 edges after accept; rst pulse during SETTLE -> all outputs 0, op_cnt=0, no res_valid.
REQ-047 Wrap: 256 back-to-back operations -> op_cnt returns to 0.
